ucode_cpool_agen: RTL and testbench

- E-stage consumer of the registered index bytes (index_byte1_e, index_byte2_e). Forms the 16-bit constant-pool index, scales it to a byte address against the constant-pool base, and sequences one- or two-word data-cache reads.
- Serves ldc/ldc_w (one word) and ldc2_w (two words).
- Returns assembled data to the microcode datapath with a done pulse. Sits between the index register stage and the DCU request port.

---
 rtl/ucode_cpool_pkg.sv | 20 ++
 rtl/ucode_cpool_add.sv | 14 +
 rtl/ucode_cpool_agen.sv | 177 +++++++++++++++++
 tb/tb_ucode_cpool_agen.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucode_cpool_pkg.sv
// ucode_cpool_pkg: shared definitions for the constant-pool address generator.
// State encoding, word stride and the index scaling helper.
package ucode_cpool_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ0 = 2'd1,
      REQ1 = 2'd2,
      DONE = 2'd3
   } cpool_state_t;

   localparam int unsigned WORD_BYTES = 4;

   // Zero-extend the 16-bit pool index and scale it to a byte offset.
   function automatic logic [31:0] scale_index(input logic [15:0] idx,
                                               input int unsigned shift);
      scale_index = {16'd0, idx} << shift;
   endfunction

endpackage

// File: rtl/ucode_cpool_add.sv
// ucode_cpool_add: ADDR_W-bit wrapping adder shared by the base+index sum
// and the second-word +WORD_BYTES increment.
module ucode_cpool_add #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] a,
   input  logic [ADDR_W-1:0] b,
   output logic [ADDR_W-1:0] sum
);

   // Carry out of the top bit is dropped, so addresses wrap modulo 2^ADDR_W.
   assign sum = a + b;

endmodule

// File: rtl/ucode_cpool_agen.sv
// ucode_cpool_agen: E-stage constant-pool address generator for ldc/ldc_w
// (one word) and ldc2_w (two words). Forms the pool index from the registered
// index bytes, scales it against cp_base and sequences DCU reads.
// Optional bounds check against cp_count is enabled by UCODE_CPOOL_BOUNDS_EN.
module ucode_cpool_agen
   import ucode_cpool_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned WORD_SHIFT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        index_byte1_e,
   input  logic [7:0]        index_byte2_e,
   input  logic [ADDR_W-1:0] cp_base,
   input  logic              start_e,
   input  logic              two_word_e,
   input  logic              iu_hold_e,
   input  logic              kill_e,
   input  logic              dcu_ack,
   input  logic [31:0]       dcu_data,
`ifdef UCODE_CPOOL_BOUNDS_EN
   input  logic [15:0]       cp_count,
   output logic              cp_fault,
`endif
   output logic              cp_req,
   output logic [ADDR_W-1:0] cp_addr,
   output logic              busy,
   output logic              done,
   output logic [31:0]       data_lo,
   output logic [31:0]       data_hi
);

   cpool_state_t      state_q;
   cpool_state_t      state_d;
   logic              two_q;
   logic [15:0]       idx;
   logic              capture;
   logic              bound_fault;
   logic [ADDR_W-1:0] scaled_idx;
   logic [ADDR_W-1:0] add_a;
   logic [ADDR_W-1:0] add_b;
   logic [ADDR_W-1:0] add_sum;
`ifdef UCODE_CPOOL_BOUNDS_EN
   logic              fault_q;
`endif

   assign idx        = {index_byte1_e, index_byte2_e};
   assign capture    = (state_q == IDLE) && start_e && !iu_hold_e && !kill_e;
   assign scaled_idx = ADDR_W'(scale_index(idx, WORD_SHIFT));

`ifdef UCODE_CPOOL_BOUNDS_EN
   // 17-bit compares so idx+1 cannot overflow when idx is 16'hFFFF.
   assign bound_fault = ({1'b0, idx} >= {1'b0, cp_count}) ||
                        (two_word_e && (({1'b0, idx} + 17'd1) >= {1'b0, cp_count}));
`else
   assign bound_fault = 1'b0;
`endif

   // One adder: in IDLE it forms base+scaled index, otherwise cp_addr+4.
   assign add_a = (state_q == IDLE) ? cp_base    : cp_addr;
   assign add_b = (state_q == IDLE) ? scaled_idx : ADDR_W'(WORD_BYTES);

   ucode_cpool_add #(
      .ADDR_W (ADDR_W)
   ) u_add (
      .a   (add_a),
      .b   (add_b),
      .sum (add_sum)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; kill_e overrides every transition including capture.
   always_comb begin
      state_d = state_q;
      if (kill_e) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (capture) begin
                  state_d = bound_fault ? DONE : REQ0;
               end
            end
            REQ0: begin
               if (dcu_ack) begin
                  state_d = two_q ? REQ1 : DONE;
               end
            end
            REQ1: begin
               if (dcu_ack) begin
                  state_d = DONE;
               end
            end
            DONE: begin
               if (!iu_hold_e) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Moore outputs decoded from the current state.
   always_comb begin
      cp_req = (state_q == REQ0) || (state_q == REQ1);
      busy   = (state_q != IDLE);
      done   = (state_q == DONE);
`ifdef UCODE_CPOOL_BOUNDS_EN
      cp_fault = fault_q;
`endif
   end

   // Address and data registers; a killed cycle discards any coincident ack.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cp_addr <= '0;
         data_lo <= '0;
         data_hi <= '0;
         two_q   <= 1'b0;
`ifdef UCODE_CPOOL_BOUNDS_EN
         fault_q <= 1'b0;
`endif
      end else if (kill_e) begin
`ifdef UCODE_CPOOL_BOUNDS_EN
         fault_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (capture) begin
                  cp_addr <= add_sum;
                  two_q   <= two_word_e;
                  data_hi <= '0;
                  if (bound_fault) begin
                     data_lo <= '0;
                  end
`ifdef UCODE_CPOOL_BOUNDS_EN
                  fault_q <= bound_fault;
`endif
               end
            end
            REQ0: begin
               if (dcu_ack) begin
                  data_lo <= dcu_data;
                  if (two_q) begin
                     cp_addr <= add_sum;
                  end
               end
            end
            REQ1: begin
               if (dcu_ack) begin
                  data_hi <= dcu_data;
               end
            end
            DONE: begin
`ifdef UCODE_CPOOL_BOUNDS_EN
               if (!iu_hold_e) begin
                  fault_q <= 1'b0;
               end
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ucode_cpool_agen.sv
// tb_ucode_cpool_agen: scoreboard bench for ucode_cpool_agen.
// Directed cases plus randomized transactions; a responder answers cp_req
// and checks addresses, a monitor checks results whenever done is high.
// Define UCODE_CPOOL_BOUNDS_EN to also exercise the bounds-check ports.
module tb_ucode_cpool_agen;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  index_byte1_e;
   logic [7:0]  index_byte2_e;
   logic [31:0] cp_base;
   logic        start_e;
   logic        two_word_e;
   logic        iu_hold_e;
   logic        kill_e;
   logic        dcu_ack;
   logic [31:0] dcu_data;
   logic        cp_req;
   logic [31:0] cp_addr;
   logic        busy;
   logic        done;
   logic [31:0] data_lo;
   logic [31:0] data_hi;
`ifdef UCODE_CPOOL_BOUNDS_EN
   logic [15:0] cp_count;
   logic        cp_fault;
`endif

   ucode_cpool_agen #(
      .ADDR_W     (32),
      .WORD_SHIFT (2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .index_byte1_e (index_byte1_e),
      .index_byte2_e (index_byte2_e),
      .cp_base       (cp_base),
      .start_e       (start_e),
      .two_word_e    (two_word_e),
      .iu_hold_e     (iu_hold_e),
      .kill_e        (kill_e),
      .dcu_ack       (dcu_ack),
      .dcu_data      (dcu_data),
`ifdef UCODE_CPOOL_BOUNDS_EN
      .cp_count      (cp_count),
      .cp_fault      (cp_fault),
`endif
      .cp_req        (cp_req),
      .cp_addr       (cp_addr),
      .busy          (busy),
      .done          (done),
      .data_lo       (data_lo),
      .data_hi       (data_hi)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      logic        flt;
   } res_t;

   res_t        exp_res[$];
   logic [31:0] exp_addr[$];
   logic [31:0] ack_dq[$];
   int          ack_wq[$];

   int n_cmp = 0;
   int n_err = 0;
   bit auto_ack = 1'b0;
   int wleft = -1;
   bit prev_done = 1'b0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Responder: answers requests after the queued wait count, checks the address each cycle.
   always @(negedge clk) begin
      if (auto_ack && !reset) begin
         if (cp_req) begin
            if (exp_addr.size() == 0) begin
               check("unexpected_req", cp_req, 0);
               dcu_ack = 1'b0;
            end else begin
               check("cp_addr", cp_addr, exp_addr[0]);
               if (wleft < 0) wleft = ack_wq[0];
               if (wleft == 0) begin
                  dcu_ack  = 1'b1;
                  dcu_data = ack_dq.pop_front();
                  void'(exp_addr.pop_front());
                  void'(ack_wq.pop_front());
                  wleft = -1;
               end else begin
                  dcu_ack  = 1'b0;
                  dcu_data = $urandom;
                  wleft--;
               end
            end
         end else begin
            dcu_ack = 1'b0;
         end
      end
   end

   // Monitor: every cycle done is high the result must match the front expectation.
   always @(negedge clk) begin
      if (!reset) begin
         if (done) begin
            if (exp_res.size() == 0) begin
               check("unexpected_done", done, 0);
            end else begin
               check("data_lo", data_lo, exp_res[0].lo);
               check("data_hi", data_hi, exp_res[0].hi);
`ifdef UCODE_CPOOL_BOUNDS_EN
               check("cp_fault", cp_fault, exp_res[0].flt);
`endif
            end
         end else if (prev_done && exp_res.size() > 0) begin
            void'(exp_res.pop_front());
         end
         prev_done = done;
      end
   end

   // One transaction: optional pre-hold in IDLE, random waits, random hold in DONE.
   task automatic do_txn(input logic [7:0] b1, input logic [7:0] b2, input logic [31:0] base,
                         input bit two, input int w0, input int w1, input int hold_n,
                         input int pre_hold, input logic [15:0] cnt);
      logic [31:0] a0;
      logic [31:0] d0;
      logic [31:0] d1;
      int          idx;
      bit          flt;
      res_t        r;
      int          lat;
      int          dl;
      idx = {b1, b2};
      a0  = base + 32'(idx * 4);
      flt = 1'b0;
`ifdef UCODE_CPOOL_BOUNDS_EN
      flt = (idx >= int'(cnt)) || (two && (idx + 1 >= int'(cnt)));
`endif
      d0 = $urandom;
      d1 = $urandom;
      if (!flt) begin
         exp_addr.push_back(a0);
         ack_dq.push_back(d0);
         ack_wq.push_back(w0);
         if (two) begin
            exp_addr.push_back(a0 + 32'd4);
            ack_dq.push_back(d1);
            ack_wq.push_back(w1);
         end
      end
      r.lo  = flt ? 32'd0 : d0;
      r.hi  = (flt || !two) ? 32'd0 : d1;
      r.flt = flt;
      exp_res.push_back(r);

      @(negedge clk);
      index_byte1_e = b1;
      index_byte2_e = b2;
      cp_base       = base;
      two_word_e    = two;
      start_e       = 1'b1;
      iu_hold_e     = (pre_hold > 0);
`ifdef UCODE_CPOOL_BOUNDS_EN
      cp_count = cnt;
`endif
      for (int i = 0; i < pre_hold; i++) begin
         @(negedge clk);
         check("no_capture_on_hold", busy, 0);
      end
      iu_hold_e = 1'b0;

      lat = 0;
      while (1) begin
         @(negedge clk);
         lat++;
         if (done || lat >= 300) break;
         start_e       = ($urandom_range(0, 3) == 0);
         index_byte1_e = 8'($urandom);
         index_byte2_e = 8'($urandom);
         iu_hold_e     = 1'($urandom_range(0, 1));
      end
      if (!done) begin
         check("done_timeout", done, 1);
         start_e   = 1'b0;
         iu_hold_e = 1'b0;
         return;
      end
      if (!flt) check("latency", lat, two ? (3 + w0 + w1) : (2 + w0));

      iu_hold_e = (hold_n > 0);
      start_e   = 1'b0;
      dl = 1;
      for (int i = 0; i < hold_n; i++) begin
         start_e = 1'b1;
         @(negedge clk);
         if (done) dl++;
      end
      start_e   = 1'b0;
      iu_hold_e = 1'b0;
      @(negedge clk);
      check("done_len", dl, hold_n + 1);
      check("done_drop", done, 0);
      check("idle_after", busy, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      index_byte1_e = '0;
      index_byte2_e = '0;
      cp_base = '0;
      start_e = 1'b0;
      two_word_e = 1'b0;
      iu_hold_e = 1'b0;
      kill_e = 1'b0;
      dcu_ack = 1'b0;
      dcu_data = '0;
`ifdef UCODE_CPOOL_BOUNDS_EN
      cp_count = 16'hFFFF;
`endif
      repeat (3) @(negedge clk);
      check("rst_cp_req", cp_req, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_cp_addr", cp_addr, 0);
      check("rst_data_lo", data_lo, 0);
      check("rst_data_hi", data_hi, 0);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_busy", busy, 0);

      auto_ack = 1'b1;
      // one-word zero-wait, two-word with waits, wrap, hold in DONE and IDLE
      do_txn(8'h01, 8'h02, 32'h1000_0000, 1'b0, 0, 0, 0, 0, 16'hFFFF);
      do_txn(8'h00, 8'h05, 32'h0000_2000, 1'b1, 3, 3, 0, 0, 16'hFFFF);
      do_txn(8'h00, 8'h01, 32'hFFFF_FFF8, 1'b1, 0, 0, 0, 0, 16'hFFFF);
      do_txn(8'h12, 8'h34, 32'h0000_8000, 1'b1, 1, 0, 4, 3, 16'hFFFF);

      // kill in REQ1 together with an ack
      auto_ack = 1'b0;
      @(negedge clk);
      index_byte1_e = 8'h00;
      index_byte2_e = 8'h07;
      cp_base = 32'h0000_3000;
      two_word_e = 1'b1;
      start_e = 1'b1;
      @(negedge clk);
      start_e = 1'b0;
      check("kill_req0", cp_req, 1);
      check("kill_addr0", cp_addr, 32'h0000_301C);
      dcu_ack = 1'b1;
      dcu_data = 32'hAAAA_5555;
      @(negedge clk);
      check("kill_req1", cp_req, 1);
      check("kill_addr1", cp_addr, 32'h0000_3020);
      kill_e = 1'b1;
      dcu_data = 32'h1234_5678;
      start_e = 1'b1;
      @(negedge clk);
      kill_e = 1'b0;
      dcu_ack = 1'b0;
      start_e = 1'b0;
      check("kill_busy", busy, 0);
      check("kill_cp_req", cp_req, 0);
      check("kill_done", done, 0);
      check("kill_data_lo", data_lo, 32'hAAAA_5555);
      check("kill_data_hi", data_hi, 32'h0);

      // kill beats capture in IDLE
      start_e = 1'b1;
      kill_e = 1'b1;
      @(negedge clk);
      start_e = 1'b0;
      kill_e = 1'b0;
      check("kill_vs_capture", busy, 0);

      // kill in REQ0 with coincident ack discards the data
      index_byte1_e = 8'h00;
      index_byte2_e = 8'h09;
      cp_base = 32'h0;
      two_word_e = 1'b0;
      start_e = 1'b1;
      @(negedge clk);
      start_e = 1'b0;
      kill_e = 1'b1;
      dcu_ack = 1'b1;
      dcu_data = 32'hDEAD_BEEF;
      @(negedge clk);
      kill_e = 1'b0;
      dcu_ack = 1'b0;
      check("kill0_busy", busy, 0);
      check("kill0_data_lo", data_lo, 32'hAAAA_5555);

      // asynchronous reset in the middle of REQ0
      index_byte2_e = 8'h02;
      cp_base = 32'h40;
      start_e = 1'b1;
      @(negedge clk);
      start_e = 1'b0;
      check("arst_req0", cp_req, 1);
      #2 reset = 1'b1;
      #1;
      check("arst_cp_req", cp_req, 0);
      check("arst_busy", busy, 0);
      check("arst_cp_addr", cp_addr, 0);
      check("arst_data_lo", data_lo, 0);
      check("arst_data_hi", data_hi, 0);
      @(negedge clk);
      reset = 1'b0;
      prev_done = 1'b0;
      @(negedge clk);

      auto_ack = 1'b1;
`ifdef UCODE_CPOOL_BOUNDS_EN
      do_txn(8'h00, 8'h04, 32'h0000_1000, 1'b1, 0, 0, 1, 0, 16'd5);
      do_txn(8'h00, 8'h03, 32'h0000_1000, 1'b1, 0, 0, 0, 0, 16'd5);
`endif
      for (int t = 0; t < 40; t++) begin
         do_txn(8'($urandom), 8'($urandom), $urandom, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0) ? 2 : 0,
                16'($urandom_range(0, 65535)));
      end

      repeat (3) @(negedge clk);
      check("leftover_results", exp_res.size(), 0);
      check("leftover_addrs", exp_addr.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
